// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
// Define BIN2BCD_SAT_EN to load all-9s into bcd when the captured value overflows.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [BCD_W-1:0] pow10(input int n);
    logic [BCD_W-1:0] v;
    v = BCD_W'(1);
    for (int k = 0; k < n; k++) v = BCD_W'(v * BCD_W'(10));
    return v;
  endfunction

  // 10^DIGITS always fits in 4*DIGITS bits, so one compare width covers every legal BIN_W.
  localparam logic [BCD_W-1:0] LIMIT = pow10(DIGITS);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_capture;
  logic              w_last;
  logic [BIN_W-1:0]  r_bin;
  logic [BCD_W-1:0]  r_scratch;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf_cap;
  logic [BCD_W-1:0]  r_bcd;
  logic              r_ovf;
  logic              r_done;
  logic [BCD_W-1:0]  w_adj;
  logic [BCD_W-1:0]  w_shift;
  logic [BCD_W-1:0]  w_bin_ext;
  logic [BCD_W-1:0]  w_result;

  assign w_bin_ext = BCD_W'(binary);

  always_comb begin
    w_adj = r_scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
    end
  end

  // Carry out of the top digit falls off here, giving value mod 10^DIGITS.
  assign w_shift = {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};

`ifdef BIN2BCD_SAT_EN
  assign w_result = r_ovf_cap ? {DIGITS{4'h9}} : w_shift;
`else
  assign w_result = w_shift;
`endif

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_capture    = 1'b1;
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_W'(BIN_W - 1)) begin
          w_last       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_ovf_cap <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_capture) begin
        r_bin     <= binary;
        r_scratch <= '0;
        r_cnt     <= '0;
        r_ovf_cap <= (w_bin_ext >= LIMIT);
      end else if (r_state == S_SHIFT) begin
        r_bin     <= r_bin << 1;
        r_scratch <= w_shift;
        r_cnt     <= r_cnt + CNT_W'(1);
      end
      if (w_last) begin
        r_bcd <= w_result;
        r_ovf <= r_ovf_cap;
      end
    end
  end

  assign busy     = (r_state == S_SHIFT);
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed-vector self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] binary;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  int total;
  int bad;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .binary   (binary),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One start pulse; measures busy length, watches bcd for partial updates, checks the result.
  task automatic run_conv(input logic [13:0] val, input logic [15:0] exp_bcd,
                          input logic exp_ovf, input string tag);
    int          busy_cnt;
    logic        seen_done;
    logic        bcd_moved;
    logic [15:0] prev_bcd;
    @(negedge clk);
    binary = val;
    start  = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    binary    = ~val;
    busy_cnt  = 0;
    seen_done = 1'b0;
    bcd_moved = 1'b0;
    prev_bcd  = bcd;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (bcd !== prev_bcd) bcd_moved = 1'b1;
      @(negedge clk);
    end
    check({tag, " done seen"}, 32'(seen_done), 32'd1);
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'd14);
    check({tag, " bcd stable while busy"}, 32'(bcd_moved), 32'd0);
    check({tag, " bcd"}, 32'(bcd), 32'(exp_bcd));
    check({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
    @(negedge clk);
    check({tag, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int          gap;
    logic        seen;
    logic [15:0] sat_exp;
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    start  = 1'b0;
    binary = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: asynchronous reset pulse while idle
    #2 rst = 1'b1;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst bcd", 32'(bcd), 32'h0);
    check("rst busy idle", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);

    // 2..4: directed conversions
    run_conv(14'd1234, 16'h1234, 1'b0, "c1234");
    run_conv(14'd0, 16'h0000, 1'b0, "c0");
`ifdef BIN2BCD_SAT_EN
    sat_exp = 16'h9999;
`else
    sat_exp = 16'h6383;
`endif
    run_conv(14'd16383, sat_exp, 1'b1, "c16383");
    run_conv(14'd9999, 16'h9999, 1'b0, "c9999");
    run_conv(14'd10000, 16'h0000 | ((sat_exp == 16'h9999) ? 16'h9999 : 16'h0000), 1'b1, "c10000");
    run_conv(14'd1, 16'h0001, 1'b0, "c1");

    // 5: start held high, value changed while busy, back-to-back acceptance
    @(negedge clk);
    binary = 14'd42;
    start  = 1'b1;
    @(negedge clk);
    binary = 14'd7;
    seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("b2b first done", 32'(seen), 32'd1);
    check("b2b first bcd", 32'(bcd), 32'h0042);
    gap  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      gap++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("b2b second done", 32'(seen), 32'd1);
    check("b2b done period", 32'(gap), 32'd15);
    check("b2b second bcd", 32'(bcd), 32'h0007);
    @(negedge clk);
    check("b2b stop idle", 32'(busy), 32'd0);

    // 6: reset 5 cycles into a conversion discards it
    @(negedge clk);
    binary = 14'd5678;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid busy before rst", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst bcd", 32'(bcd), 32'h0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("mid rst no done", 32'(seen), 32'd0);
    run_conv(14'd5678, 16'h5678, 1'b0, "c5678");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
